// File: rtl/reduce_exec_if.sv
// reduce_exec_if: handshake bundle between the reduction engine and its two FIFOs.
//   ififo_rdy      input FIFO non-empty, idata valid (show-ahead)
//   idata          input FIFO head word
//   ififo_pop      engine consumes the head word this cycle
//   op_mode        operator presented alongside a header word
//   ofifo_not_full output FIFO can accept a word
//   ofifo_push     engine writes odata this cycle
//   odata          result word
// Modport master is the engine side; slave is the FIFO/environment side.
interface reduce_exec_if #(
  parameter int DWIDTH = 8
);
  logic              ififo_rdy;
  logic [DWIDTH-1:0] idata;
  logic              ififo_pop;
  logic [1:0]        op_mode;
  logic              ofifo_not_full;
  logic              ofifo_push;
  logic [DWIDTH-1:0] odata;

  modport master (
    input  ififo_rdy,
    input  idata,
    input  op_mode,
    input  ofifo_not_full,
    output ififo_pop,
    output ofifo_push,
    output odata
  );

  modport slave (
    output ififo_rdy,
    output idata,
    output op_mode,
    output ofifo_not_full,
    input  ififo_pop,
    input  ofifo_push,
    input  odata
  );
endinterface

// File: rtl/reduce_exec.sv
// reduce_exec: packet-reduction engine. Reads length-prefixed packets from a
// show-ahead input FIFO, folds the payload with XOR/ADD/AND/OR chosen at the
// header, and pushes one result word per packet into the output FIFO.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   bus        reduce_exec_if.master (input/output FIFO handshakes, op_mode, odata)
//   exec_idle  high while in IDLE
//   err_len    one-cycle pulse after a header longer than MAX_LEN is popped
//   pkt_cnt    results pushed since reset, wrapping
//   state      current FSM encoding (IDLE=0, DATA=1, PUSH=2)
module reduce_exec #(
  parameter int DWIDTH   = 8,
  parameter int CNTWIDTH = 8,
  parameter int MAX_LEN  = 255,
  parameter int PCWIDTH  = 16
) (
  input  logic               clk,
  input  logic               rst,
  reduce_exec_if.master      bus,
  output logic               exec_idle,
  output logic               err_len,
  output logic [PCWIDTH-1:0] pkt_cnt,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PUSH = 2'd2
  } state_t;

  state_t              cur_state;
  state_t              nxt_state;
  logic [DWIDTH-1:0]   acc;
  logic [CNTWIDTH-1:0] cnt;
  logic [1:0]          op;

  logic [CNTWIDTH-1:0] hdr_len;
  logic                hdr_load;
  logic                data_pop;
  logic                pop;
  logic                push;
  logic [DWIDTH-1:0]   identity;
  logic [DWIDTH-1:0]   combined;

  // Upper header bits beyond the length field are ignored.
  assign hdr_len = bus.idata[CNTWIDTH-1:0];

  // AND must start from all-ones so the first payload word passes through.
  assign identity = (bus.op_mode == 2'd2) ? '1 : '0;

  always_comb begin
    combined = acc;
    case (op)
      2'd0:    combined = acc ^ bus.idata;
      2'd1:    combined = acc + bus.idata;
      2'd2:    combined = acc & bus.idata;
      default: combined = acc | bus.idata;
    endcase
  end

  // Next-state and handshake decode. A header may be taken either from IDLE
  // or in the same cycle the previous result is pushed, which is what lets
  // back-to-back packets run without a bubble.
  always_comb begin
    nxt_state = cur_state;
    pop       = 1'b0;
    push      = 1'b0;
    hdr_load  = 1'b0;
    data_pop  = 1'b0;
    case (cur_state)
      IDLE: begin
        if (bus.ififo_rdy) begin
          pop       = 1'b1;
          hdr_load  = 1'b1;
          nxt_state = (hdr_len == '0) ? PUSH : DATA;
        end
      end
      DATA: begin
        if (bus.ififo_rdy) begin
          pop      = 1'b1;
          data_pop = 1'b1;
          if (cnt == CNTWIDTH'(1)) nxt_state = PUSH;
        end
      end
      PUSH: begin
        if (bus.ofifo_not_full) begin
          push = 1'b1;
          if (bus.ififo_rdy) begin
            pop       = 1'b1;
            hdr_load  = 1'b1;
            nxt_state = (hdr_len == '0) ? PUSH : DATA;
          end else begin
            nxt_state = IDLE;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) cur_state <= IDLE;
    else     cur_state <= nxt_state;
  end

  // Datapath: accumulator, remaining count, latched operator and status.
  // An oversize length only flags err_len; the packet is still consumed in
  // full so the stream stays aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      op      <= 2'd0;
      pkt_cnt <= '0;
      err_len <= 1'b0;
    end else begin
      err_len <= hdr_load && (32'(hdr_len) > 32'(MAX_LEN));
      if (hdr_load) begin
        cnt <= hdr_len;
        op  <= bus.op_mode;
        acc <= identity;
      end else if (data_pop) begin
        acc <= combined;
        cnt <= cnt - CNTWIDTH'(1);
      end
      if (push) pkt_cnt <= pkt_cnt + PCWIDTH'(1);
    end
  end

  assign bus.ififo_pop  = pop;
  assign bus.ofifo_push = push;
  assign bus.odata      = acc;
  assign exec_idle      = (cur_state == IDLE);
  assign state          = cur_state;

endmodule

// File: tb/tb_reduce_exec.sv
// tb_reduce_exec: randomized and directed bench for reduce_exec. Packets are
// queued as words tagged with header/op information; an independent reference
// reduction produces the expected result for every packet.
module tb_reduce_exec;

  localparam int MAX_LEN = 4;

  logic        clk;
  logic        rst;
  logic        exec_idle;
  logic        err_len;
  logic [15:0] pkt_cnt;
  logic [1:0]  state;

  reduce_exec_if #(.DWIDTH(8)) bus ();

  reduce_exec #(
    .DWIDTH(8), .CNTWIDTH(8), .MAX_LEN(MAX_LEN), .PCWIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .exec_idle(exec_idle), .err_len(err_len), .pkt_cnt(pkt_cnt), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       hdr;
    logic [1:0] op;
  } word_t;

  word_t      wq[$];
  logic [7:0] res_q[$];
  int         checks = 0;
  int         fails = 0;
  int         exp_pkts = 0;
  logic       exp_err = 1'b0;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference reduction straight from the operator definitions.
  function automatic logic [7:0] reduceRef(input logic [1:0] op, input logic [7:0] w[$]);
    logic [7:0] r;
    r = (op == 2'd2) ? 8'hFF : 8'h00;
    for (int i = 1; i <= int'(w[0]); i++) begin
      case (op)
        2'd0:    r = r ^ w[i];
        2'd1:    r = 8'((int'(r) + int'(w[i])) % 256);
        2'd2:    r = r & w[i];
        default: r = r | w[i];
      endcase
    end
    return r;
  endfunction

  // Queue a packet (w[0] is the header) and its expected result.
  task automatic addPacket(input logic [1:0] op, input logic [7:0] w[$]);
    word_t e;
    foreach (w[i]) begin
      e.data = w[i];
      e.hdr  = (i == 0);
      e.op   = op;
      wq.push_back(e);
    end
    res_q.push_back(reduceRef(op, w));
    exp_pkts++;
  endtask

  task automatic addRandomPacket();
    logic [7:0] w[$];
    int         len;
    len = $urandom_range(0, 7);
    w.push_back(8'(len));
    for (int i = 0; i < len; i++) w.push_back(8'($urandom_range(0, 255)));
    addPacket(2'($urandom_range(0, 3)), w);
  endtask

  // Run the queued stream with random input gaps and output backpressure.
  // span returns cycles from the first pop to the last push.
  task automatic applyStimulus(input int gap_pct, input int bp_pct, output int span);
    int    cyc;
    int    first_pop;
    int    last_push;
    word_t w;
    cyc = 0;
    first_pop = -1;
    last_push = 0;
    while ((wq.size() > 0 || res_q.size() > 0) && cyc < 5000) begin
      @(negedge clk);
      bus.ififo_rdy      = (wq.size() > 0) && ($urandom_range(0, 99) >= gap_pct);
      bus.idata          = bus.ififo_rdy ? wq[0].data : 8'($urandom_range(0, 255));
      bus.op_mode        = (wq.size() > 0 && wq[0].hdr) ? wq[0].op : 2'($urandom_range(0, 3));
      bus.ofifo_not_full = ($urandom_range(0, 99) >= bp_pct);
      #1;
      checkOutput("err_len", 32'(err_len), 32'(exp_err));
      checkOutput("pop_gate", 32'(bus.ififo_pop & ~bus.ififo_rdy), 0);
      checkOutput("push_gate", 32'(bus.ofifo_push & ~bus.ofifo_not_full), 0);
      exp_err = 1'b0;
      if (bus.ofifo_push) begin
        if (res_q.size() == 0) checkOutput("push_extra", 1, 0);
        else checkOutput("odata", 32'(bus.odata), 32'(res_q.pop_front()));
        last_push = cyc;
      end
      if (bus.ififo_pop && bus.ififo_rdy) begin
        w = wq.pop_front();
        if (first_pop < 0) first_pop = cyc;
        if (w.hdr && int'(w.data) > MAX_LEN) exp_err = 1'b1;
      end
      cyc++;
    end
    if (cyc >= 5000) checkOutput("timeout", 1, 0);
    @(negedge clk);
    bus.ififo_rdy      = 1'b0;
    bus.ofifo_not_full = 1'b1;
    #1;
    checkOutput("err_len_tail", 32'(err_len), 32'(exp_err));
    checkOutput("idle_after", 32'(exec_idle), 1);
    checkOutput("no_push_after", 32'(bus.ofifo_push), 0);
    checkOutput("pkt_cnt", 32'(pkt_cnt), 32'(exp_pkts % 65536));
    exp_err = 1'b0;
    span = last_push - first_pop;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    bus.ififo_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_pkts = 0;
    exp_err  = 1'b0;
  endtask

  initial begin
    logic [7:0] p[$];
    int         span;

    rst = 1'b1;
    bus.ififo_rdy = 1'b0;
    bus.idata = 8'h00;
    bus.op_mode = 2'd0;
    bus.ofifo_not_full = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_state", 32'(state), 0);
    checkOutput("rst_idle", 32'(exec_idle), 1);
    checkOutput("rst_odata", 32'(bus.odata), 0);
    checkOutput("rst_pkt_cnt", 32'(pkt_cnt), 0);
    checkOutput("rst_pop", 32'(bus.ififo_pop), 0);
    checkOutput("rst_push", 32'(bus.ofifo_push), 0);
    checkOutput("rst_err", 32'(err_len), 0);
    rst = 1'b0;

    // XOR single packet, full throughput.
    p = '{8'h04, 8'h16, 8'h05, 8'h08, 8'hFF};
    addPacket(2'd0, p);
    applyStimulus(0, 0, span);
    checkOutput("xor_span", 32'(span), 5);

    // ADD back-to-back with same-cycle handoff.
    p = '{8'h03, 8'h44, 8'h76, 8'h65};
    addPacket(2'd1, p);
    p = '{8'h01, 8'h10};
    addPacket(2'd1, p);
    applyStimulus(0, 0, span);
    checkOutput("add_span", 32'(span), 6);

    // AND zero-length then a two-word packet.
    p = '{8'h00};
    addPacket(2'd2, p);
    p = '{8'h02, 8'hF0, 8'h3C};
    addPacket(2'd2, p);
    applyStimulus(0, 0, span);
    checkOutput("and_span", 32'(span), 4);

    // OR with input gaps and output backpressure.
    p = '{8'h03, 8'h01, 8'h02, 8'h04};
    addPacket(2'd3, p);
    applyStimulus(40, 40, span);

    // Oversize header: err_len pulse, packet still consumed in full.
    p = '{8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    addPacket(2'd0, p);
    applyStimulus(0, 0, span);
    checkOutput("err_span", 32'(span), 7);

    // Random mixed stream.
    for (int i = 0; i < 40; i++) addRandomPacket();
    applyStimulus(20, 20, span);
    for (int i = 0; i < 20; i++) addRandomPacket();
    applyStimulus(0, 0, span);

    // Reset in DATA after two of four payload words.
    @(negedge clk);
    bus.ififo_rdy = 1'b1; bus.idata = 8'h04; bus.op_mode = 2'd0; bus.ofifo_not_full = 1'b1;
    @(negedge clk);
    bus.idata = 8'h11;
    @(negedge clk);
    bus.idata = 8'h22;
    @(negedge clk);
    bus.ififo_rdy = 1'b0;
    #1;
    checkOutput("mid_state", 32'(state), 1);
    checkOutput("mid_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkts % 65536));
    rst = 1'b1;
    #1;
    checkOutput("mid_no_push", 32'(bus.ofifo_push), 0);
    @(negedge clk);
    #1;
    checkOutput("abort_state", 32'(state), 0);
    checkOutput("abort_idle", 32'(exec_idle), 1);
    checkOutput("abort_odata", 32'(bus.odata), 0);
    checkOutput("abort_push", 32'(bus.ofifo_push), 0);
    checkOutput("abort_pkt_cnt", 32'(pkt_cnt), 0);
    applyReset();

    // Engine resumes cleanly after the abort.
    p = '{8'h02, 8'h0F, 8'hF0};
    addPacket(2'd3, p);
    applyStimulus(0, 0, span);
    checkOutput("resume_span", 32'(span), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
